// File: rtl/chip8_alu_seq_if.sv
// Bus between the 8XYN sequencer and its environment (requester, register file, ALU).
// start is a one-cycle request honoured only while busy=0; done pulses for one cycle per accepted start, with err alongside it.
interface chip8_alu_seq_if;
   logic        start;
   logic [15:0] opcode;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  rf_addr;
   logic [7:0]  rf_wdata;
   logic        rf_we;
   logic [7:0]  rf_rdata;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [2:0]  alu_sel;
   logic [15:0] alu_out;
   logic        alu_carry;

   modport master (
      output start, opcode, rf_rdata, alu_out, alu_carry,
      input  busy, done, err, rf_addr, rf_wdata, rf_we, alu_in1, alu_in2, alu_sel
   );

   modport slave (
      input  start, opcode, rf_rdata, alu_out, alu_carry,
      output busy, done, err, rf_addr, rf_wdata, rf_we, alu_in1, alu_in2, alu_sel
   );
endinterface

// File: rtl/chip8_alu_seq.sv
// Sequencer for Chip-8 8XYN ops: reads VX/VY, drives an external ALU, writes VX then VF.
module chip8_alu_seq (
   input  logic             clk,
   input  logic             reset_n,
   chip8_alu_seq_if.slave   bus,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {IDLE, RD_X, RD_Y, LATCH_Y, EXEC, WB_X, WB_F, DONE} state_t;
   typedef enum logic [2:0] {ALU_OR, ALU_AND, ALU_XOR, ALU_ADD, ALU_MINUS, ALU_RSHIFT, ALU_LSHIFT} ALU_f;

   state_t      state, state_next;
   logic [15:0] op_q;
   logic [7:0]  vx, vy, res;
   logic        flag, flag_next;
   ALU_f        alu_sel;
   logic [3:0]  x, y, n;

   assign x = op_q[11:8];
   assign y = op_q[7:4];
   assign n = op_q[3:0];

   function automatic logic supported(input logic [3:0] nib);
      return (nib <= 4'h7) || (nib == 4'hE);
   endfunction

   function automatic logic writes_flag(input logic [3:0] nib);
      return supported(nib) && (nib >= 4'h4);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         op_q  <= '0;
         vx    <= '0;
         vy    <= '0;
         res   <= '0;
         flag  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.start) op_q <= bus.opcode;
         if (state == RD_Y)    vx <= bus.rf_rdata;
         if (state == LATCH_Y) vy <= bus.rf_rdata;
         if (state == EXEC) begin
            res  <= bus.alu_out[7:0];
            flag <= flag_next;
         end
      end
   end

   always_comb begin
      state_next   = state;
      bus.busy     = (state != IDLE);
      bus.done     = 1'b0;
      bus.err      = 1'b0;
      bus.rf_addr  = 4'h0;
      bus.rf_wdata = 8'h00;
      bus.rf_we    = 1'b0;
      bus.alu_in1  = 16'h0000;
      bus.alu_in2  = 16'h0000;
      alu_sel      = ALU_OR;
      flag_next    = 1'b0;
      case (state)
         IDLE: begin
            // Unsupported N skips the register file entirely and reports at once.
            if (bus.start) state_next = supported(bus.opcode[3:0]) ? RD_X : DONE;
         end
         RD_X: begin
            bus.rf_addr = x;
            state_next  = RD_Y;
         end
         RD_Y: begin
            bus.rf_addr = y;
            state_next  = LATCH_Y;
         end
         LATCH_Y: state_next = EXEC;
         EXEC: begin
            bus.alu_in1 = {8'h00, vx};
            bus.alu_in2 = {8'h00, vy};
            case (n)
               4'h0: begin alu_sel = ALU_OR; bus.alu_in1 = {8'h00, vy}; bus.alu_in2 = 16'h0000; end
               4'h1: alu_sel = ALU_OR;
               4'h2: alu_sel = ALU_AND;
               4'h3: alu_sel = ALU_XOR;
               4'h4: begin alu_sel = ALU_ADD;   flag_next = bus.alu_carry; end
               4'h5: begin alu_sel = ALU_MINUS; flag_next = bus.alu_carry; end
               4'h6: begin alu_sel = ALU_RSHIFT; bus.alu_in2 = 16'h0001; flag_next = vx[0]; end
               4'h7: begin
                  alu_sel     = ALU_MINUS;
                  bus.alu_in1 = {8'h00, vy};
                  bus.alu_in2 = {8'h00, vx};
                  flag_next   = bus.alu_carry;
               end
               4'hE: begin alu_sel = ALU_LSHIFT; bus.alu_in2 = 16'h0001; flag_next = vx[7]; end
               default: alu_sel = ALU_OR;
            endcase
            state_next = WB_X;
         end
         WB_X: begin
            bus.rf_we    = 1'b1;
            bus.rf_addr  = x;
            bus.rf_wdata = res;
            state_next   = writes_flag(n) ? WB_F : DONE;
         end
         // Flag lands after the result so X=F leaves the flag in VF.
         WB_F: begin
            bus.rf_we    = 1'b1;
            bus.rf_addr  = 4'hF;
            bus.rf_wdata = {7'b0, flag};
            state_next   = DONE;
         end
         DONE: begin
            bus.done   = 1'b1;
            bus.err    = !supported(n);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.alu_sel = alu_sel;
   assign state_dbg   = state;

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Directed and random 8XYN ops against a register-file/ALU environment and a rule-level reference model.
module tb_chip8_alu_seq;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   chip8_alu_seq_if bus ();
   logic [2:0] state_dbg;

   chip8_alu_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  rf [16];
   logic [7:0]  ref_rf [16];
   logic [11:0] exp_q [$];
   logic        pre_we = 1'b0;
   logic [3:0]  pre_addr = 4'h0;
   logic [7:0]  pre_data = 8'h00;

   // Register file: synchronous read, write from DUT or bench preload
   always @(posedge clk) begin
      if (pre_we) rf[pre_addr] <= pre_data;
      else if (bus.rf_we) rf[bus.rf_addr] <= bus.rf_wdata;
      bus.rf_rdata <= rf[bus.rf_addr];
   end

   // ALU environment (encoding OR,AND,XOR,ADD,MINUS,RSHIFT,LSHIFT = 0..6)
   always_comb begin
      bus.alu_out   = 16'h0000;
      bus.alu_carry = 1'b0;
      case (bus.alu_sel)
         3'd0: bus.alu_out = bus.alu_in1 | bus.alu_in2;
         3'd1: bus.alu_out = bus.alu_in1 & bus.alu_in2;
         3'd2: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
         3'd3: begin
            bus.alu_out   = bus.alu_in1 + bus.alu_in2;
            bus.alu_carry = (bus.alu_in1 + bus.alu_in2) > 16'h00FF;
         end
         3'd4: begin
            bus.alu_out   = bus.alu_in1 - bus.alu_in2;
            bus.alu_carry = bus.alu_in1 >= bus.alu_in2;
         end
         3'd5: bus.alu_out = bus.alu_in1 >> bus.alu_in2;
         3'd6: bus.alu_out = bus.alu_in1 << bus.alu_in2;
         default: bus.alu_out = 16'h0000;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every register write must match the head of exp_q
   always @(negedge clk) begin
      if (reset_n && bus.rf_we) begin
         if (exp_q.size() == 0) check("unexpected_write", {bus.rf_addr, bus.rf_wdata}, 12'hFFF);
         else check("rf_write", {bus.rf_addr, bus.rf_wdata}, exp_q.pop_front());
      end
      if (bus.err) check("err_with_done", bus.done, 1'b1);
   end

   // Reference model written from the opcode rules
   task automatic model(input logic [15:0] op, output logic [7:0] r, output logic f,
                        output logic hf, output logic sup);
      int a, b;
      a = ref_rf[op[11:8]];
      b = ref_rf[op[7:4]];
      r = 8'h00; f = 1'b0; hf = 1'b0; sup = 1'b1;
      case (op[3:0])
         4'h0: r = b[7:0];
         4'h1: r = 8'(a | b);
         4'h2: r = 8'(a & b);
         4'h3: r = 8'(a ^ b);
         4'h4: begin r = 8'((a + b) % 256); f = (a + b) > 255; hf = 1'b1; end
         4'h5: begin r = 8'((a - b + 256) % 256); f = a >= b; hf = 1'b1; end
         4'h6: begin r = 8'(a / 2); f = (a % 2) == 1; hf = 1'b1; end
         4'h7: begin r = 8'((b - a + 256) % 256); f = b >= a; hf = 1'b1; end
         4'hE: begin r = 8'((a * 2) % 256); f = a >= 128; hf = 1'b1; end
         default: sup = 1'b0;
      endcase
   endtask

   task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
      ref_rf[a] = d;
   endtask

   // Runs one op; entered and left at a negedge. no_wait starts in the current cycle.
   task automatic run_op(input logic [15:0] op, input bit noise, input bit no_wait);
      logic [7:0] r;
      logic f, hf, sup;
      int cyc, exp_cyc;
      model(op, r, f, hf, sup);
      if (sup) begin
         exp_q.push_back({op[11:8], r});
         if (hf) exp_q.push_back({4'hF, 7'b0, f});
      end
      exp_cyc = !sup ? 1 : (hf ? 7 : 6);
      if (!no_wait) @(negedge clk);
      check("idle_not_busy", bus.busy, 1'b0);
      bus.start = 1'b1;
      bus.opcode = op;
      @(negedge clk);
      bus.start = 1'b0;
      bus.opcode = 16'($urandom);
      cyc = 1;
      check("busy_after_start", bus.busy, 1'b1);
      while (!bus.done && cyc < 20) begin
         if (cyc != 4) check("alu_idle_zero", {bus.alu_in1, bus.alu_in2}, 32'h0);
         else check("alu_upper_zero", {bus.alu_in1[15:8], bus.alu_in2[15:8]}, 16'h0);
         if (noise && cyc == 2) begin
            bus.start = 1'b1;
            bus.opcode = 16'($urandom);
         end else bus.start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check("latency", cyc, exp_cyc);
      check("err", bus.err, !sup);
      check("sb_drained", exp_q.size(), 0);
      if (sup) begin
         ref_rf[op[11:8]] = r;
         if (hf) ref_rf[15] = {7'b0, f};
      end
   endtask

   initial begin
      logic [7:0] r;
      logic f, hf, sup;
      logic [15:0] op;
      bus.start = 1'b0;
      bus.opcode = 16'h0000;
      #12;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done_err", {bus.done, bus.err}, 2'b00);
      check("rst_rf", {bus.rf_we, bus.rf_addr, bus.rf_wdata}, 13'h0);
      check("rst_alu", {bus.alu_sel, bus.alu_in1, bus.alu_in2}, 35'h0);
      @(negedge clk);
      for (int i = 0; i < 16; i++) set_reg(4'(i), 8'($urandom));
      reset_n = 1'b1;

      // Start accepted on the first edge after reset release
      set_reg(4'h1, 8'hF0);
      set_reg(4'h2, 8'h20);
      run_op(16'h8124, 1'b0, 1'b1);
      check("v1_add", rf[1], 8'h10);
      check("vf_add", rf[15], 8'h01);

      set_reg(4'h3, 8'h05); set_reg(4'h4, 8'h09);
      run_op(16'h8345, 1'b0, 1'b0);
      check("v3_sub", rf[3], 8'hFC);
      check("vf_sub_borrow", rf[15], 8'h00);
      set_reg(4'h3, 8'h09); set_reg(4'h4, 8'h05);
      run_op(16'h8345, 1'b0, 1'b0);
      check("v3_sub2", rf[3], 8'h04);
      check("vf_sub_noborrow", rf[15], 8'h01);

      set_reg(4'hA, 8'h81);
      run_op(16'h8A0E, 1'b0, 1'b0);
      check("va_shl", rf[10], 8'h02);
      check("vf_shl", rf[15], 8'h01);
      set_reg(4'hA, 8'h81);
      run_op(16'h8A06, 1'b0, 1'b0);
      check("va_shr", rf[10], 8'h40);
      check("vf_shr", rf[15], 8'h01);

      set_reg(4'hF, 8'h0F); set_reg(4'h0, 8'h3C);
      run_op(16'h8F02, 1'b0, 1'b0);
      check("vf_and_xf", rf[15], 8'h0C);

      // Unsupported op followed immediately by a supported one
      run_op(16'h8129, 1'b0, 1'b0);
      run_op(16'h8121, 1'b1, 1'b0);

      // Random back-to-back ops with start noise while busy
      for (int k = 0; k < 40; k++) begin
         op = {4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15))};
         run_op(op, ($urandom_range(0, 1) == 1), 1'b0);
      end

      // Abort during WB_X
      set_reg(4'h1, 8'h5A); set_reg(4'h2, 8'hC3);
      model(16'h8124, r, f, hf, sup);
      exp_q.push_back({4'h1, r});
      bus.start = 1'b1; bus.opcode = 16'h8124;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_in_wbx", bus.rf_we, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_we", bus.rf_we, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      exp_q.delete();
      @(negedge clk);
      check("abort_no_write", rf[1], 8'h5A);
      reset_n = 1'b1;
      run_op(16'h8120, 1'b0, 1'b1);
      check("copy_after_abort", rf[1], 8'hC3);

      for (int i = 0; i < 16; i++) check("final_rf", rf[i], ref_rf[i]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chip8_alu_seq.md
CHIP8_ALU_SEQ -- requirements
Module: chip8_alu_seq

Interface
REQ-001 clk  input  1  Single system clock; all state updates on its rising edge.
REQ-002 reset_n  input  1  Asynchronous, active-low reset.
REQ-003 start  input  1  One-cycle request to execute the 8XYN opcode on `opcode`; sampled only in IDLE.
REQ-004 opcode  input  16  Chip-8 instruction; bits [15:12] are ignored, X=[11:8], Y=[7:4], N=[3:0].
REQ-005 busy  output  1  High in every state except IDLE.
REQ-006 done  output  1  One-cycle completion pulse.
REQ-007 err  output  1  One-cycle pulse coincident with done when N is unsupported.
REQ-008 rf_addr  output  4  Register file address.
REQ-009 rf_wdata  output  8  Register file write data.
REQ-010 rf_we  output  1  Register file write enable.
REQ-011 rf_rdata  input  8  Register file read data, valid the cycle after rf_addr is presented.
REQ-012 alu_in1, alu_in2  output  16 each  ALU operands; upper byte is always zero.
REQ-013 alu_sel  output  ALU_f  ALU function select, from enums.svh.
REQ-014 alu_out  input  16  ALU combinational result.
REQ-015 alu_carry  input  1  ALU combinational carry/compare flag.

Function
REQ-016 States SHALL be IDLE, RD_X, RD_Y, LATCH_Y, EXEC, WB_X, WB_F, DONE.
REQ-017 IDLE with start=1 SHALL latch opcode and then go to RD_X if N is supported, or to DONE with err flagged otherwise.
REQ-018 IDLE with start=0 SHALL remain in IDLE; start while busy SHALL be ignored and SHALL NOT corrupt the latched opcode.
REQ-019 RD_X drives rf_addr=X; RD_Y drives rf_addr=Y and captures rf_rdata as vx; LATCH_Y captures rf_rdata as vy.
REQ-020 EXEC SHALL drive the ALU from registered operands and register res=alu_out[7:0] and flag per REQ-022.
REQ-021 Opcode mapping (N: sel, in1, in2):
  - 0: OR, vy, 0.
  - 1: OR, vx, vy.
  - 2: AND, vx, vy.
  - 3: XOR, vx, vy.
  - 4: ADD, vx, vy.
  - 5: MINUS, vx, vy.
  - 6: RSHIFT, vx, 1.
  - 7: MINUS, vy, vx.
  - E: LSHIFT, vx, 1.
REQ-022 Flag rules:
  - N=4,5,7: flag=alu_carry.
  - N=6: flag=vx[0].
  - N=E: flag=vx[7].
  - N=0..3: no VF write; WB_F is skipped (WB_X goes directly to DONE).
REQ-023 Unsupported N (8,9,A,B,C,D,F) SHALL cause no register file access.
REQ-024 WB_X SHALL assert rf_we=1 for one cycle with rf_addr=X and rf_wdata=res.
REQ-025 WB_F SHALL assert rf_we=1 for one cycle with rf_addr=4'hF and rf_wdata={7'b0,flag}.
REQ-026 When X=F, the flag write (WB_F) SHALL occur after the result write, so VF holds the flag.
REQ-027 DONE SHALL assert done=1 for one cycle and return to IDLE; err=1 only for the unsupported path.
REQ-028 Latency, with start accepted in cycle 0:
  - Flag ops: done in cycle 7.
  - N=0..3: done in cycle 6.
  - Unsupported N: done in cycle 1.
REQ-029 A new start SHALL be accepted in the cycle the block is back in IDLE after DONE (back-to-back throughput).
REQ-030 Arithmetic SHALL be 8-bit with wrap-around: the result is alu_out[7:0], and the upper byte is discarded after the flag is taken.
REQ-031 rf_we SHALL be 0 in every state other than WB_X and WB_F.
REQ-032 alu_sel SHALL be the enum default value and alu_in1, alu_in2 SHALL be 0 outside EXEC.

Reset
REQ-033 While reset_n=0, the state SHALL be IDLE, all outputs SHALL be 0, and the internal vx, vy, res, flag and opcode registers SHALL be 0, independent of clk.
REQ-034 A reset asserted mid-operation SHALL abort immediately: rf_we drops in the same cycle, and no done or err is generated for the aborted op.
REQ-035 After reset_n rises, the block SHALL accept start on the first rising edge.

Verification
REQ-036 8XY4 with V1=0xF0, V2=0x20, X=1, Y=2:
  - Writes V1=0x10, then VF=0x01.
  - done in cycle 7, err=0.
REQ-037 8XY5 with V3=0x05, V4=0x09:
  - Writes V3=0xFC, then VF=0x00.
  - Swapping values (V3=0x09, V4=0x05) gives V3=0x04, VF=0x01.
REQ-038 8XYE with VA=0x81:
  - Writes VA=0x02, then VF=0x01.
  - 8XY6 with VA=0x81 writes VA=0x40, VF=0x01.
REQ-039 8F02 (X=F, AND) with VF=0x0F, V0=0x3C:
  - Writes only VF=0x0C.
  - done in cycle 6, no WB_F cycle.
REQ-040 Opcode 0x8129 (N=9):
  - done=1 and err=1 in cycle 1.
  - rf_we never asserts; an immediate following start is accepted.
REQ-041 reset_n pulsed low during WB_X:
  - rf_we, busy and done go 0 asynchronously.
  - The next start (8120) completes normally with V1=V2.
